stage3_argmax_classifier: RTL and testbench

STAGE3_ARGMAX_CLASSIFIER -- requirements
Module: stage3_argmax_classifier

---
 rtl/stage3_argmax_classifier_pkg.sv | 17 +
 rtl/stage3_argmax_step.sv | 31 +++
 rtl/stage3_argmax_classifier.sv | 189 ++++++++++++++++++
 tb/tb_stage3_argmax_classifier.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage3_argmax_classifier_pkg.sv
// Shared definitions for the stage-3 argmax classifier: default parameter
// values and the controller state encoding.
package stage3_argmax_classifier_pkg;

  localparam int         DEF_NUM_CLASS   = 3;
  localparam int         DEF_SCORE_BW    = 20;
  localparam logic [7:0] DEF_CHAR_BASE   = 8'h61;
  localparam logic [7:0] DEF_REJECT_CHAR = 8'h3F;
  localparam int         DEF_MARGIN      = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/stage3_argmax_step.sv
// One compare/update step of the running argmax. Strictly-greater tests only,
// so on a tie the earlier (lower-index) class keeps the win.
module stage3_argmax_step #(
  parameter int SCORE_BW = 20,
  parameter int IDX_W    = 2
) (
  input  logic signed [SCORE_BW-1:0] score_i,
  input  logic signed [SCORE_BW-1:0] best_i,
  input  logic signed [SCORE_BW-1:0] second_i,
  input  logic        [IDX_W-1:0]    idx_i,
  input  logic        [IDX_W-1:0]    best_idx_i,
  output logic signed [SCORE_BW-1:0] best_o,
  output logic signed [SCORE_BW-1:0] second_o,
  output logic        [IDX_W-1:0]    best_idx_o
);

  // New best pushes the old best down to second; otherwise maybe raise second.
  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    best_idx_o = best_idx_i;
    if (score_i > best_i) begin
      second_o   = best_i;
      best_o     = score_i;
      best_idx_o = idx_i;
    end else if (score_i > second_i) begin
      second_o = score_i;
    end
  end

endmodule

// File: rtl/stage3_argmax_classifier.sv
// Stage-3 argmax classifier: latches a frame of signed class scores, scans
// them one class per cycle to find the best and second-best, then emits an
// ASCII character (or a reject code when the winning margin is too small).
//
// Handshake: o_ready is high exactly when the block is idle; a frame is taken
// on any rising edge where i_in_valid && o_ready. A frame offered while
// o_ready is low is discarded and reported by a one-cycle o_drop pulse.
// o_valid is a one-cycle pulse with no back-pressure; result fields hold
// until the next result.
module stage3_argmax_classifier
  import stage3_argmax_classifier_pkg::*;
#(
  parameter int         NUM_CLASS   = DEF_NUM_CLASS,
  parameter int         SCORE_BW    = DEF_SCORE_BW,
  parameter logic [7:0] CHAR_BASE   = DEF_CHAR_BASE,
  parameter int         MARGIN      = DEF_MARGIN,
  parameter logic [7:0] REJECT_CHAR = DEF_REJECT_CHAR,
  localparam int        IDX_W       = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_in_valid,
  input  logic [NUM_CLASS*SCORE_BW-1:0] i_in_core,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic [7:0]                    o_alpha,
  output logic [NUM_CLASS-1:0]          o_led,
  output logic [IDX_W-1:0]              o_class_idx,
  output logic                          o_reject,
  output logic                          o_drop,
  output logic [1:0]                    o_dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
  localparam logic signed [SCORE_BW-1:0] MOST_NEG = {1'b1, {(SCORE_BW-1){1'b0}}};

  state_e state_q, state_d;

  logic [NUM_CLASS*SCORE_BW-1:0] core_q, core_d;
  logic signed [SCORE_BW-1:0]    best_q, best_d;
  logic signed [SCORE_BW-1:0]    second_q, second_d;
  logic [IDX_W-1:0]              best_idx_q, best_idx_d;
  logic [IDX_W-1:0]              scan_idx_q, scan_idx_d;

  logic                 valid_q, valid_d;
  logic [7:0]           alpha_q, alpha_d;
  logic [NUM_CLASS-1:0] led_q, led_d;
  logic [IDX_W-1:0]     class_idx_q, class_idx_d;
  logic                 reject_q, reject_d;
  logic                 drop_q, drop_d;

  // Score under examination this SCAN cycle, taken from the latched frame.
  logic [31:0]                scan_base;
  logic signed [SCORE_BW-1:0] score_k;
  logic signed [SCORE_BW-1:0] step_best, step_second;
  logic [IDX_W-1:0]           step_best_idx;

  assign scan_base = 32'(scan_idx_q) * 32'(SCORE_BW);
  assign score_k   = core_q[scan_base +: SCORE_BW];

  stage3_argmax_step #(
    .SCORE_BW (SCORE_BW),
    .IDX_W    (IDX_W)
  ) u_step (
    .score_i    (score_k),
    .best_i     (best_q),
    .second_i   (second_q),
    .idx_i      (scan_idx_q),
    .best_idx_i (best_idx_q),
    .best_o     (step_best),
    .second_o   (step_second),
    .best_idx_o (step_best_idx)
  );

  // Gap is one bit wider than a score so extreme values cannot overflow.
  logic signed [SCORE_BW:0] gap;
  logic signed [31:0]       gap_w;
  logic                     reject_now;
  logic [7:0]               alpha_acc;
  logic [NUM_CLASS-1:0]     led_acc;

  assign gap        = {best_q[SCORE_BW-1], best_q} - {second_q[SCORE_BW-1], second_q};
  assign gap_w      = 32'(gap);
  assign reject_now = (NUM_CLASS > 1) && (gap_w < MARGIN);
  assign alpha_acc  = CHAR_BASE + 8'(best_idx_q);

  // One-hot winner display; class 0 lights the most significant LED.
  always_comb begin
    led_acc = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (best_idx_q == IDX_W'(k)) led_acc[NUM_CLASS-1-k] = 1'b1;
    end
  end

  // Controller state register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, datapath updates and result formation.
  always_comb begin
    state_d     = state_q;
    core_d      = core_q;
    best_d      = best_q;
    second_d    = second_q;
    best_idx_d  = best_idx_q;
    scan_idx_d  = scan_idx_q;
    valid_d     = 1'b0;
    alpha_d     = alpha_q;
    led_d       = led_q;
    class_idx_d = class_idx_q;
    reject_d    = reject_q;
    drop_d      = i_in_valid && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (i_in_valid) begin
          core_d     = i_in_core;
          best_d     = i_in_core[SCORE_BW-1:0];
          best_idx_d = '0;
          second_d   = MOST_NEG;
          scan_idx_d = IDX_W'(1);
          state_d    = (NUM_CLASS > 1) ? ST_SCAN : ST_RESULT;
        end
      end
      ST_SCAN: begin
        best_d     = step_best;
        second_d   = step_second;
        best_idx_d = step_best_idx;
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == LAST_IDX) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        valid_d     = 1'b1;
        class_idx_d = best_idx_q;
        if (reject_now) begin
          alpha_d  = REJECT_CHAR;
          led_d    = '0;
          reject_d = 1'b1;
        end else begin
          alpha_d  = alpha_acc;
          led_d    = led_acc;
          reject_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output registers; all cleared while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_q      <= '0;
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      scan_idx_q  <= '0;
      valid_q     <= 1'b0;
      alpha_q     <= 8'h00;
      led_q       <= '0;
      class_idx_q <= '0;
      reject_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      core_q      <= core_d;
      best_q      <= best_d;
      second_q    <= second_d;
      best_idx_q  <= best_idx_d;
      scan_idx_q  <= scan_idx_d;
      valid_q     <= valid_d;
      alpha_q     <= alpha_d;
      led_q       <= led_d;
      class_idx_q <= class_idx_d;
      reject_q    <= reject_d;
      drop_q      <= drop_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_valid     = valid_q;
  assign o_alpha     = alpha_q;
  assign o_led       = led_q;
  assign o_class_idx = class_idx_q;
  assign o_reject    = reject_q;
  assign o_drop      = drop_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_stage3_argmax_classifier.sv
// Bench for stage3_argmax_classifier. Four instances share clock, reset,
// valid and the score vector: three 3-class/16-bit instances with margins
// 0, 10 and 100, and one 8-class instance. A frame-level model predicts each
// instance's results, which a per-cycle compare process checks.
module tb_stage3_argmax_classifier;
  import stage3_argmax_classifier_pkg::*;

  typedef struct {
    int         lane;
    int         due;
    logic [7:0] alpha;
    logic [7:0] led;
    logic [2:0] idx;
    logic       rej;
  } res_t;

  int lane_n      [4] = '{3, 3, 3, 8};
  int lane_margin [4] = '{0, 10, 100, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_valid = 1'b0;
  logic signed [15:0] sc [8];
  logic [47:0]       core3;
  logic [127:0]      core8;

  always_comb begin
    core3 = '0;
    core8 = '0;
    for (int k = 0; k < 3; k++) core3[k*16 +: 16] = sc[k];
    for (int k = 0; k < 8; k++) core8[k*16 +: 16] = sc[k];
  end

  // ---------------- DUTs ----------------
  logic       v0, v1, v2, v3, r0, r1, r2, r3, j0, j1, j2, j3, d0, d1, d2, d3;
  logic [7:0] a0, a1, a2, a3;
  logic [2:0] l0, l1, l2;
  logic [7:0] l3;
  logic [1:0] x0, x1, x2;
  logic [2:0] x3;
  logic [1:0] s0, s1, s2, s3;

  stage3_argmax_classifier #(.NUM_CLASS(3), .SCORE_BW(16), .MARGIN(0)) dut_m0 (
    .clk(clk), .reset(rst), .i_in_valid(i_valid), .i_in_core(core3), .o_ready(r0),
    .o_valid(v0), .o_alpha(a0), .o_led(l0), .o_class_idx(x0), .o_reject(j0),
    .o_drop(d0), .o_dbg_state(s0));
  stage3_argmax_classifier #(.NUM_CLASS(3), .SCORE_BW(16), .MARGIN(10)) dut_m10 (
    .clk(clk), .reset(rst), .i_in_valid(i_valid), .i_in_core(core3), .o_ready(r1),
    .o_valid(v1), .o_alpha(a1), .o_led(l1), .o_class_idx(x1), .o_reject(j1),
    .o_drop(d1), .o_dbg_state(s1));
  stage3_argmax_classifier #(.NUM_CLASS(3), .SCORE_BW(16), .MARGIN(100)) dut_m100 (
    .clk(clk), .reset(rst), .i_in_valid(i_valid), .i_in_core(core3), .o_ready(r2),
    .o_valid(v2), .o_alpha(a2), .o_led(l2), .o_class_idx(x2), .o_reject(j2),
    .o_drop(d2), .o_dbg_state(s2));
  stage3_argmax_classifier #(.NUM_CLASS(8), .SCORE_BW(16), .MARGIN(0)) dut_c8 (
    .clk(clk), .reset(rst), .i_in_valid(i_valid), .i_in_core(core8), .o_ready(r3),
    .o_valid(v3), .o_alpha(a3), .o_led(l3), .o_class_idx(x3), .o_reject(j3),
    .o_drop(d3), .o_dbg_state(s3));

  logic       lane_valid [4];
  logic       lane_ready [4];
  logic       lane_rej   [4];
  logic       lane_drop  [4];
  logic [7:0] lane_alpha [4];
  logic [7:0] lane_led   [4];
  logic [2:0] lane_idx   [4];
  logic [1:0] lane_state [4];

  assign lane_valid = '{v0, v1, v2, v3};
  assign lane_ready = '{r0, r1, r2, r3};
  assign lane_rej   = '{j0, j1, j2, j3};
  assign lane_drop  = '{d0, d1, d2, d3};
  assign lane_alpha = '{a0, a1, a2, a3};
  assign lane_led   = '{{5'b0, l0}, {5'b0, l1}, {5'b0, l2}, l3};
  assign lane_idx   = '{{1'b0, x0}, {1'b0, x1}, {1'b0, x2}, x3};
  assign lane_state = '{s0, s1, s2, s3};

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Frame-level reference: winner is the first position holding the maximum,
  // runner-up is the largest of all other scores, gap is plain integer math.
  function automatic res_t model(input int n, input int margin, input logic signed [15:0] s [8]);
    res_t r;
    int bi, best, second, gap;
    bi = 0;
    for (int k = 1; k < n; k++) if (int'(s[k]) > int'(s[bi])) bi = k;
    best   = int'(s[bi]);
    second = -32768;
    for (int k = 0; k < n; k++) if (k != bi && int'(s[k]) > second) second = int'(s[k]);
    gap    = best - second;
    r.lane = 0;
    r.due  = 0;
    r.idx  = 3'(bi);
    r.rej  = (n > 1) && (gap < margin);
    if (r.rej) begin
      r.alpha = 8'h3F;
      r.led   = 8'h00;
    end else begin
      r.alpha = 8'(32'h61 + bi);
      r.led   = 8'(1 << (n - 1 - bi));
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  res_t exp_q [$];
  res_t last  [4];
  int   ready_from [4];
  logic exp_drop   [4];
  int   edge_cnt = 0;

  // Model side: sees the same inputs as the DUTs at each rising edge.
  always @(posedge clk) begin
    res_t r;
    logic rdy;
    edge_cnt++;
    if (rst) exp_q.delete();
    for (int l = 0; l < 4; l++) begin
      if (rst) begin
        ready_from[l] = 0;
        exp_drop[l]   = 1'b0;
        last[l].alpha = 8'h00;
        last[l].led   = 8'h00;
        last[l].idx   = 3'd0;
        last[l].rej   = 1'b0;
      end else begin
        rdy         = (edge_cnt - 1 >= ready_from[l]);
        exp_drop[l] = i_valid && !rdy;
        if (i_valid && rdy) begin
          r      = model(lane_n[l], lane_margin[l], sc);
          r.lane = l;
          r.due  = edge_cnt + lane_n[l];
          exp_q.push_back(r);
          ready_from[l] = edge_cnt + lane_n[l];
        end
      end
    end
  end

  // Compare side: every cycle, on the falling edge.
  always @(negedge clk) begin
    logic ev;
    logic rdy_exp;
    for (int l = 0; l < 4; l++) begin
      if (rst) begin
        chk($sformatf("lane%0d_rst_valid", l), lane_valid[l], 0);
        chk($sformatf("lane%0d_rst_alpha", l), lane_alpha[l], 0);
        chk($sformatf("lane%0d_rst_led", l), lane_led[l], 0);
        chk($sformatf("lane%0d_rst_idx", l), lane_idx[l], 0);
        chk($sformatf("lane%0d_rst_rej", l), lane_rej[l], 0);
        chk($sformatf("lane%0d_rst_drop", l), lane_drop[l], 0);
        chk($sformatf("lane%0d_rst_ready", l), lane_ready[l], 1);
      end else begin
        ev = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].lane == l && exp_q[i].due == edge_cnt) begin
            ev      = 1'b1;
            last[l] = exp_q[i];
            exp_q.delete(i);
            break;
          end
        end
        rdy_exp = (edge_cnt >= ready_from[l]);
        chk($sformatf("lane%0d_valid", l), lane_valid[l], ev);
        chk($sformatf("lane%0d_alpha", l), lane_alpha[l], last[l].alpha);
        chk($sformatf("lane%0d_led", l), lane_led[l], last[l].led);
        chk($sformatf("lane%0d_idx", l), lane_idx[l], last[l].idx);
        chk($sformatf("lane%0d_rej", l), lane_rej[l], last[l].rej);
        chk($sformatf("lane%0d_drop", l), lane_drop[l], exp_drop[l]);
        chk($sformatf("lane%0d_ready", l), lane_ready[l], rdy_exp);
        chk($sformatf("lane%0d_state_idle", l), lane_state[l] == ST_IDLE, rdy_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set3(input int s0v, input int s1v, input int s2v);
    sc[0] = 16'(s0v);
    sc[1] = 16'(s1v);
    sc[2] = 16'(s2v);
    for (int k = 3; k < 8; k++) sc[k] = 16'sd0;
  endtask

  // Offer one frame (caller at negedge+1, lane idle) and count rising edges
  // from the accept edge, inclusive, until that lane's o_valid is seen.
  task automatic send_and_time(input int lane, output int edges, output bit ok);
    i_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    #1 i_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (lane_valid[lane]) ok = 1'b1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        #1;
      end
    end
    chk($sformatf("lane%0d_result_seen", lane), ok, 1);
  endtask

  function automatic logic signed [15:0] rnd_score(input int mode);
    int pick;
    case (mode)
      0: return 16'($urandom_range(0, 65535));
      1: return 16'(int'($urandom_range(0, 6)) - 3);
      default: begin
        pick = int'($urandom_range(0, 4));
        case (pick)
          0: return 16'sh7FFF;
          1: return 16'sh8000;
          2: return 16'sd0;
          3: return 16'sd1;
          default: return -16'sd1;
        endcase
      end
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    res_t pin;
    int   edges;
    bit   ok;
    logic signed [15:0] ps [8];

    for (int k = 0; k < 8; k++) sc[k] = 16'sd0;

    // Pin the reference model against hand-computed results.
    for (int k = 0; k < 8; k++) ps[k] = 16'sd0;
    ps[0] = 16'sd100; ps[1] = -16'sd5; ps[2] = 16'sd40;
    pin = model(3, 0, ps);
    chk("pin_a_alpha", pin.alpha, 8'h61);
    chk("pin_a_led", pin.led, 8'b100);
    ps[0] = -16'sd30; ps[1] = -16'sd30; ps[2] = -16'sd50;
    pin = model(3, 10, ps);
    chk("pin_tie_rej", pin.rej, 1);
    chk("pin_tie_idx", pin.idx, 0);
    ps[0] = 16'sh7FFF; ps[1] = 16'sh8000; ps[2] = 16'sh8000;
    pin = model(3, 100, ps);
    chk("pin_ext_alpha", pin.alpha, 8'h61);
    for (int k = 0; k < 7; k++) ps[k] = 16'(k);
    ps[7] = 16'sd50;
    pin = model(8, 0, ps);
    chk("pin_c8_led", pin.led, 8'h01);

    // Reset, then a frame in the very first cycle after release.
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    set3(100, -5, 40);
    send_and_time(0, edges, ok);
    chk("lat3_first", edges, 4);
    chk("a_alpha", lane_alpha[0], 8'h61);
    chk("a_led", lane_led[0], 8'b100);
    chk("a_idx", lane_idx[0], 0);
    chk("a_rej", lane_rej[0], 0);
    chk("a_m100_rej", lane_rej[2], 1);

    set3(-30, -30, -50);
    send_and_time(0, edges, ok);
    chk("tie0_alpha", lane_alpha[0], 8'h61);
    set3(-50, 7, 7);
    send_and_time(0, edges, ok);
    chk("tie1_alpha", lane_alpha[0], 8'h62);
    chk("tie1_led", lane_led[0], 8'b010);

    set3(20, 25, -32768);
    send_and_time(1, edges, ok);
    chk("m10_rej_alpha", lane_alpha[1], 8'h3F);
    chk("m10_rej_led", lane_led[1], 0);
    chk("m10_rej_flag", lane_rej[1], 1);
    chk("m10_rej_idx", lane_idx[1], 1);
    set3(20, 35, 0);
    send_and_time(1, edges, ok);
    chk("m10_acc_alpha", lane_alpha[1], 8'h62);

    set3(32767, -32768, -32768);
    send_and_time(2, edges, ok);
    chk("ext_alpha", lane_alpha[2], 8'h61);
    chk("ext_rej", lane_rej[2], 0);

    // Busy drop, then a frame offered in the o_valid cycle.
    idle_cycles(1);
    set3(5, 9, 1);
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    #1 set3(50, 0, 0);
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_drop_pulse", lane_drop[0], 1);
    #1 i_valid = 1'b0;
    set3(-7, -7, -7);
    @(negedge clk);
    chk("busy_first_valid", lane_valid[0], 1);
    chk("busy_first_alpha", lane_alpha[0], 8'h62);
    chk("busy_drop_once", lane_drop[0], 0);
    #1 set3(0, 0, 9);
    send_and_time(0, edges, ok);
    chk("b2b_latency", edges, 4);
    chk("b2b_alpha", lane_alpha[0], 8'h63);

    // Reset in the second SCAN cycle aborts the frame.
    idle_cycles(12);
    set3(10, 20, 30);
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_alpha", lane_alpha[0], 8'h00);
    chk("rst_mid_valid", lane_valid[0], 0);
    #1 rst = 1'b0;
    set3(1, 2, 3);
    send_and_time(0, edges, ok);
    chk("post_rst_latency", edges, 4);
    chk("post_rst_alpha", lane_alpha[0], 8'h63);
    chk("post_rst_led", lane_led[0], 8'b001);

    // Eight-class instance: class 7 wins.
    idle_cycles(12);
    for (int k = 0; k < 7; k++) sc[k] = 16'(int'($urandom_range(0, 1999)) - 1000);
    sc[7] = 16'sd2000;
    send_and_time(3, edges, ok);
    chk("c8_latency", edges, 9);
    chk("c8_alpha", lane_alpha[3], 8'h68);
    chk("c8_led", lane_led[3], 8'h01);
    chk("c8_idx", lane_idx[3], 7);

    // Random traffic with scores changing every cycle and rare resets.
    for (int c = 0; c < 1500; c++) begin
      int mode;
      @(negedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
      end
      i_valid = ($urandom_range(0, 2) == 0);
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) sc[k] = rnd_score(mode);
    end

    idle_cycles(15);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
